nrzi_stuffer: RTL and testbench

Parametrised USB transmit line encoder that combines bit stuffing, NRZI encoding and EOP/abort signalling in one block. It sits between the CRC stage and the `dpdm` driver in the host transmit chain. It replaces the separate `bit_stuff` and `nrzi` pair. Over those blocks it adds a configurable run length, a raw (no-stuff) mode, a configurable EOP length and a bit-stuff-error abort sequence.

---
 rtl/usb_tx_pkg.sv | 32 +++
 rtl/nrzi_stuffer_if.sv | 25 ++
 rtl/nrzi_stuffer_fsm.sv | 112 +++++++++++
 rtl/nrzi_stuffer.sv | 123 ++++++++++++
 tb/tb_nrzi_stuffer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit chain.
//   nrzi_stuff_state_t : state encoding of the NRZI/bit-stuff line encoder
//   nrzi_stuff_act_t   : per-cycle action the encoder FSM requests from the datapath
//   USB_J_LEVEL        : line level of the J (idle) state
//   USB_DEFAULT_MAX_RUN: run of 1s after which a 0 is stuffed
//   NRZI_CNT_W         : width of the EOP/abort cycle counter
package usb_tx_pkg;

    localparam logic USB_J_LEVEL         = 1'b1;
    localparam int   USB_DEFAULT_MAX_RUN = 6;
    localparam int   NRZI_CNT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_ABORT,
        ST_EOP_SE0,
        ST_EOP_J
    } nrzi_stuff_state_t;

    typedef enum logic [2:0] {
        ACT_IDLE,   // drive idle level
        ACT_FIRST,  // encode the first packet bit, run restarts
        ACT_DATA,   // encode the upstream bit
        ACT_STUFF,  // encode a stuffed 0
        ACT_HOLD,   // abort: encode a 1 (hold level), upstream ignored
        ACT_SE0,    // drive SE0
        ACT_J       // drive J, finish packet
    } nrzi_stuff_act_t;

endpackage

// File: rtl/nrzi_stuffer_if.sv
// Serial transmit bus between the upstream bit source and the line encoder.
//   start/s_in/endb/abort : upstream -> encoder
//   pause                 : encoder -> upstream, hold s_in/endb this cycle
//   s_out/se0/busy/done   : encoder -> line driver / sequencer
interface nrzi_stuffer_if;
    logic start;
    logic s_in;
    logic endb;
    logic abort;
    logic pause;
    logic s_out;
    logic se0;
    logic busy;
    logic done;

    modport master (
        output start, s_in, endb, abort,
        input  pause, s_out, se0, busy, done
    );

    modport slave (
        input  start, s_in, endb, abort,
        output pause, s_out, se0, busy, done
    );
endinterface

// File: rtl/nrzi_stuffer_fsm.sv
// Sequencing FSM of the line encoder: chooses the datapath action for each
// cycle and counts the abort and EOP SE0 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start/endb/abort : upstream controls
//   busy       : a packet is in flight (start is ignored while high)
//   endb_lat   : last bit already taken, EOP follows the pending stuff
//   run_hit    : the current data bit completes a run of MAX_RUN 1s
//   act        : datapath action for this cycle's edge
//   pause      : upstream must hold its bit (high throughout STUFF)
module nrzi_stuffer_fsm
    import usb_tx_pkg::*;
#(
    parameter int MAX_RUN      = USB_DEFAULT_MAX_RUN,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            endb,
    input  logic            abort,
    input  logic            busy,
    input  logic            endb_lat,
    input  logic            run_hit,
    output nrzi_stuff_act_t act,
    output logic            pause
);

    nrzi_stuff_state_t     state, state_nxt;
    logic [NRZI_CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act       = ACT_IDLE;
        pause     = 1'b0;
        case (state)
            ST_IDLE: begin
                // busy is still high during the done cycle, so a start there is dropped
                if (start && !busy) begin
                    act       = ACT_FIRST;
                    state_nxt = endb ? ST_EOP_SE0 : ST_DATA;
                    cnt_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    // the abort edge itself is the first of MAX_RUN+1 held cycles
                    act       = ACT_HOLD;
                    state_nxt = ST_ABORT;
                    cnt_nxt   = '0;
                end else begin
                    act = ACT_DATA;
                    if (run_hit) begin
                        state_nxt = ST_STUFF;
                    end else if (endb) begin
                        state_nxt = ST_EOP_SE0;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_STUFF: begin
                pause = 1'b1;
                if (abort) begin
                    act       = ACT_HOLD;
                    state_nxt = ST_ABORT;
                    cnt_nxt   = '0;
                end else begin
                    act       = ACT_STUFF;
                    state_nxt = endb_lat ? ST_EOP_SE0 : ST_DATA;
                    cnt_nxt   = '0;
                end
            end
            ST_ABORT: begin
                act = ACT_HOLD;
                if (cnt == NRZI_CNT_W'(MAX_RUN - 1)) begin
                    state_nxt = ST_EOP_SE0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + NRZI_CNT_W'(1);
                end
            end
            ST_EOP_SE0: begin
                act = ACT_SE0;
                if (cnt == NRZI_CNT_W'(EOP_SE0_BITS - 1)) begin
                    state_nxt = ST_EOP_J;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + NRZI_CNT_W'(1);
                end
            end
            ST_EOP_J: begin
                act       = ACT_J;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/nrzi_stuffer.sv
// USB transmit line encoder: bit stuffing, NRZI encoding, EOP and abort.
// Every output is registered from the action chosen in the previous cycle,
// so a bit sampled at an edge is on s_out right after that edge.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nrzi_stuffer_if (start/s_in/endb/abort in,
//           pause/s_out/se0/busy/done out)
module nrzi_stuffer
    import usb_tx_pkg::*;
#(
    parameter int   MAX_RUN      = USB_DEFAULT_MAX_RUN,
    parameter bit   STUFF_EN     = 1'b1,
    parameter logic IDLE_LEVEL   = USB_J_LEVEL,
    parameter int   EOP_SE0_BITS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    nrzi_stuffer_if.slave  bus
);

    localparam int RUN_W = $clog2(MAX_RUN + 2);

    nrzi_stuff_act_t act;
    logic             level, level_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic             endb_lat, endb_nxt;
    logic             line_nxt, se0_nxt, done_nxt, busy_nxt;
    logic             run_hit;

    // A 0 toggles the line, a 1 keeps it.
    function automatic logic nrzi_enc(input logic lvl, input logic b);
        return b ? lvl : ~lvl;
    endfunction

    // Saturates so raw mode never wraps the run count.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
        return (r == RUN_W'(MAX_RUN)) ? r : r + RUN_W'(1);
    endfunction

    assign run_hit = STUFF_EN && bus.s_in && (run == RUN_W'(MAX_RUN - 1));

    nrzi_stuffer_fsm #(
        .MAX_RUN      (MAX_RUN),
        .EOP_SE0_BITS (EOP_SE0_BITS)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bus.start),
        .endb     (bus.endb),
        .abort    (bus.abort),
        .busy     (bus.busy),
        .endb_lat (endb_lat),
        .run_hit  (run_hit),
        .act      (act),
        .pause    (bus.pause)
    );

    always_comb begin
        level_nxt = level;
        run_nxt   = run;
        endb_nxt  = endb_lat;
        line_nxt  = level;
        se0_nxt   = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = bus.busy & ~bus.done;
        case (act)
            ACT_IDLE: line_nxt = IDLE_LEVEL;
            ACT_FIRST: begin
                level_nxt = nrzi_enc(level, bus.s_in);
                run_nxt   = RUN_W'(bus.s_in);
                endb_nxt  = bus.endb;
                busy_nxt  = 1'b1;
                line_nxt  = level_nxt;
            end
            ACT_DATA: begin
                level_nxt = nrzi_enc(level, bus.s_in);
                run_nxt   = bus.s_in ? run_inc(run) : '0;
                endb_nxt  = endb_lat | bus.endb;
                line_nxt  = level_nxt;
            end
            ACT_STUFF: begin
                level_nxt = ~level;
                run_nxt   = '0;
                line_nxt  = level_nxt;
            end
            ACT_HOLD: line_nxt = level;
            ACT_SE0: begin
                line_nxt = 1'b0;
                se0_nxt  = 1'b1;
            end
            ACT_J: begin
                line_nxt  = IDLE_LEVEL;
                level_nxt = IDLE_LEVEL;
                run_nxt   = '0;
                endb_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: line_nxt = IDLE_LEVEL;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= IDLE_LEVEL;
            run       <= '0;
            endb_lat  <= 1'b0;
            bus.s_out <= IDLE_LEVEL;
            bus.se0   <= 1'b0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            level     <= level_nxt;
            run       <= run_nxt;
            endb_lat  <= endb_nxt;
            bus.s_out <= line_nxt;
            bus.se0   <= se0_nxt;
            bus.done  <= done_nxt;
            bus.busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_nrzi_stuffer.sv
// Scoreboard bench for nrzi_stuffer. Three instances cover the default
// configuration, raw mode with MAX_RUN=3 and a single SE0 cycle, and
// stuffing with MAX_RUN=3. Expected line cycles {s_out,se0,done,pause}
// are queued before each packet; one monitor per instance pops and
// compares an entry on every falling edge while busy is high.
module tb_nrzi_stuffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start, s_in, endb, abort;
    int   sel;

    int checks = 0;
    int errors = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] q2[$];

    nrzi_stuffer_if ifa ();
    nrzi_stuffer_if ifb ();
    nrzi_stuffer_if ifc ();

    assign ifa.start = start && (sel == 0);
    assign ifb.start = start && (sel == 1);
    assign ifc.start = start && (sel == 2);
    assign ifa.s_in  = s_in;
    assign ifb.s_in  = s_in;
    assign ifc.s_in  = s_in;
    assign ifa.endb  = endb;
    assign ifb.endb  = endb;
    assign ifc.endb  = endb;
    assign ifa.abort = abort;
    assign ifb.abort = abort;
    assign ifc.abort = abort;

    nrzi_stuffer dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    nrzi_stuffer #(.MAX_RUN(3), .STUFF_EN(1'b0), .EOP_SE0_BITS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    nrzi_stuffer #(.MAX_RUN(3), .STUFF_EN(1'b1), .EOP_SE0_BITS(2))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic pause_of(input int d);
        return (d == 0) ? ifa.pause : (d == 1) ? ifb.pause : ifc.pause;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? ifa.busy : (d == 1) ? ifb.busy : ifc.busy;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    endfunction

    task automatic push(input int d, input logic [3:0] v);
        case (d)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // n data cycles; bit i of lv is the line level, bit i of pv the pause flag
    task automatic push_data(input int d, input int n, input logic [31:0] lv, input logic [31:0] pv);
        for (int i = 0; i < n; i++) push(d, {lv[i], 1'b0, 1'b0, pv[i]});
    endtask

    task automatic push_eop(input int d, input int nse0);
        for (int i = 0; i < nse0; i++) push(d, 4'b0100);
        push(d, 4'b1010);
    endtask

    // Drives n bits LSB-first, honouring pause; abort_at/start_at mark
    // the bit index carrying abort or a (to be ignored) extra start.
    task automatic send(input int d, input int n, input logic [31:0] bits,
                        input int abort_at, input int start_at);
        logic p;
        int   i;
        int   guard;
        @(negedge clk);
        sel   = d;
        start = 1'b1;
        s_in  = bits[0];
        endb  = (n == 1);
        abort = (abort_at == 0);
        p     = pause_of(d);
        i     = 0;
        guard = 0;
        while (i < n) begin
            @(negedge clk);
            guard++;
            if (!p) i++;
            start = (i == start_at);
            abort = (i == abort_at);
            if (i < n) begin
                s_in = bits[i];
                endb = (i == n - 1);
            end else begin
                s_in = 1'b0;
                endb = 1'b0;
            end
            p = pause_of(d);
            if (guard > 100) begin
                check("send pause stuck", 8'(p), 8'd0);
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        s_in  = 1'b0;
        endb  = 1'b0;
    endtask

    task automatic wait_idle(input int d, input string name);
        int t = 0;
        while (busy_of(d) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check({name, " busy timeout"}, 8'd1, 8'd0);
        check({name, " leftover expected"}, 8'(qsize(d)), 8'd0);
        @(negedge clk);
    endtask

    task automatic monitor_step(input int d, input string name, input logic [3:0] obs);
        logic [3:0] e;
        if (qsize(d) == 0) begin
            check({name, " unexpected output"}, {4'd0, obs}, 8'hFF);
        end else begin
            case (d)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check({name, " line"}, {4'd0, obs}, {4'd0, e});
        end
    endtask

    always @(negedge clk) if (rst_n && ifa.busy) monitor_step(0, "a", {ifa.s_out, ifa.se0, ifa.done, ifa.pause});
    always @(negedge clk) if (rst_n && ifb.busy) monitor_step(1, "b", {ifb.s_out, ifb.se0, ifb.done, ifb.pause});
    always @(negedge clk) if (rst_n && ifc.busy) monitor_step(2, "c", {ifc.s_out, ifc.se0, ifc.done, ifc.pause});

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        s_in  = 1'b0;
        endb  = 1'b0;
        abort = 1'b0;
        sel   = 0;
        repeat (2) @(negedge clk);
        check("a reset", {3'd0, ifa.s_out, ifa.se0, ifa.busy, ifa.done, ifa.pause}, 8'b0001_0000);
        check("b reset", {3'd0, ifb.s_out, ifb.se0, ifb.busy, ifb.done, ifb.pause}, 8'b0001_0000);
        check("c reset", {3'd0, ifc.s_out, ifc.se0, ifc.busy, ifc.done, ifc.pause}, 8'b0001_0000);
        rst_n = 1'b1;
        @(negedge clk);

        // eight 0s toggle every cycle; a start on bit 3 is ignored
        push_data(0, 8, 32'hAA, 32'h0);
        push_eop(0, 2);
        send(0, 8, 32'h00, -1, 3);
        wait_idle(0, "a zeros");

        // eight 1s: stuff after the sixth
        push_data(0, 9, 32'h03F, 32'h020);
        push_eop(0, 2);
        send(0, 8, 32'hFF, -1, -1);
        wait_idle(0, "a ones");

        // endb on the sixth 1: stuff bit precedes EOP
        push_data(0, 7, 32'h3F, 32'h20);
        push_eop(0, 2);
        send(0, 6, 32'h3F, -1, -1);
        wait_idle(0, "a endb stuff");

        // abort on bit 2: seven held cycles, trailing s_in/endb ignored
        push_data(0, 9, 32'h1FE, 32'h0);
        push_eop(0, 2);
        send(0, 8, 32'hB4, 2, -1);
        wait_idle(0, "a abort");

        // abort together with endb on the last bit
        push_data(0, 8, 32'hFF, 32'h0);
        push_eop(0, 2);
        send(0, 2, 32'h3, 1, -1);
        wait_idle(0, "a abort endb");

        // start and endb together: one-bit packet
        push_data(0, 1, 32'h0, 32'h0);
        push_eop(0, 2);
        send(0, 1, 32'h0, -1, -1);
        wait_idle(0, "a one bit");

        // reset in the middle of DATA after levels 0,1,0
        push_data(0, 3, 32'h2, 32'h0);
        @(negedge clk);
        sel   = 0;
        start = 1'b1;
        s_in  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("a mid reset", {3'd0, ifa.s_out, ifa.se0, ifa.busy, ifa.done, ifa.pause}, 8'b0001_0000);
        check("a mid reset leftover", 8'(q0.size()), 8'd0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fresh packet after reset starts from level 1
        push_data(0, 3, 32'h2, 32'h0);
        push_eop(0, 2);
        send(0, 3, 32'h0, -1, -1);
        wait_idle(0, "a after reset");

        // raw mode, MAX_RUN=3, one SE0 cycle
        push_data(1, 8, 32'hFF, 32'h0);
        push_eop(1, 1);
        send(1, 8, 32'hFF, -1, -1);
        wait_idle(1, "b raw ones");

        // MAX_RUN=3: stuffs after bits 3 and 6
        push_data(2, 10, 32'h387, 32'h044);
        push_eop(2, 2);
        send(2, 8, 32'hFF, -1, -1);
        wait_idle(2, "c ones");

        // MAX_RUN=3 abort: four held cycles
        push_data(2, 5, 32'h0, 32'h0);
        push_eop(2, 2);
        send(2, 3, 32'h0, 1, -1);
        wait_idle(2, "c abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
